// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable frame width, chip-select count,
// CPOL/CPHA mode, bit order, sclk divider and inter-frame gap, with an
// echo mode that retransmits the last received word.
module spi_master_param #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CS     = 1,
    parameter int DIV_WIDTH  = 8,
    parameter int GAP_WIDTH  = 8,
    parameter int CS_SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  loopback,
    input  logic [CS_SEL_W-1:0]   cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [GAP_WIDTH-1:0]  gap,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [NUM_CS-1:0]     cs_bar,
    output logic                  ready,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_done
);

    localparam int EW = $clog2(2 * DATA_WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP} state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d, div_q, div_d;
    logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d, gap_q, gap_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                  cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic                  sclk_q, sclk_d, mosi_q, mosi_d;
    logic                  ready_q, ready_d, busy_q, busy_d;
    logic                  rx_valid_q, rx_valid_d, tx_done_q, tx_done_d;
    logic [NUM_CS-1:0]     cs_bar_q, cs_bar_d;
    logic [DATA_WIDTH-1:0] load_w;
    logic                  tick, last_edge, leading;

    // Bit that goes out next, given the configured order.
    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // MSB-first fills from bit 0 upward; LSB-first fills from the top down.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                       input logic b, input logic lsb);
        return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
    endfunction

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        edge_cnt_d = edge_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        gap_d      = gap_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_bar_d   = cs_bar_q;
        ready_d    = ready_q;
        rx_valid_d = 1'b0;
        tx_done_d  = 1'b0;
        load_w     = loopback ? rx_data_q : tx_data;
        tick       = (div_cnt_q == div_q);
        last_edge  = (edge_cnt_q == EW'(2 * DATA_WIDTH - 1));
        leading    = ~edge_cnt_q[0];

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                if (start) begin
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsb_d      = lsb_first;
                    div_d      = clk_div;
                    gap_d      = gap;
                    tx_sh_d    = load_w;
                    rx_sh_d    = '0;
                    mosi_d     = ~cpha & head_bit(load_w, lsb_first);
                    // Out-of-range selects leave every line deasserted.
                    for (int i = 0; i < NUM_CS; i++)
                        cs_bar_d[i] = (cs_sel != CS_SEL_W'(i));
                    ready_d    = 1'b0;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = S_LEAD;
                end
            end
            S_LEAD: begin
                if (tick) begin
                    div_cnt_d = '0;
                    state_d   = S_SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end
            end
            S_SHIFT: begin
                if (!tick) begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end else begin
                    div_cnt_d  = '0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + EW'(1);
                    if (leading) begin
                        if (!cpha_q) begin
                            rx_sh_d = shift_in(rx_sh_q, miso, lsb_q);
                        end else begin
                            mosi_d  = head_bit(tx_sh_q, lsb_q);
                            tx_sh_d = shift_out(tx_sh_q, lsb_q);
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_sh_d = shift_in(rx_sh_q, miso, lsb_q);
                        end else if (!last_edge) begin
                            // First bit was presented in LEAD, so advance first.
                            tx_sh_d = shift_out(tx_sh_q, lsb_q);
                            mosi_d  = head_bit(shift_out(tx_sh_q, lsb_q), lsb_q);
                        end
                    end
                    if (last_edge)
                        state_d = S_TRAIL;
                end
            end
            S_TRAIL: begin
                if (!tick) begin
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
                end else begin
                    div_cnt_d  = '0;
                    cs_bar_d   = '1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                    tx_done_d  = 1'b1;
                    gap_cnt_d  = '0;
                    if (gap_q == '0) begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == gap_q - GAP_WIDTH'(1)) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = ~ready_d;
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            div_q      <= '0;
            edge_cnt_q <= '0;
            gap_cnt_q  <= '0;
            gap_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_bar_q   <= '1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            edge_cnt_q <= edge_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_q      <= gap_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_bar_q   <= cs_bar_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_bar   = cs_bar_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_done  = tx_done_q;

endmodule
